srt_digit_gen: RTL and testbench

SRT_DIGIT_GEN -- requirements
Module: srt_digit_gen

---
 rtl/srt_digit_gen.sv | 137 +++++++++++++
 tb/tb_srt_digit_gen.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/srt_digit_gen.sv
// Radix-2 SRT quotient digit generator.
// Produces 16 signed quotient digits {-1,0,+1}, MSB first, for x/d with
// x < d and d normalized, feeding a downstream on-the-fly converter.
module srt_digit_gen (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] dividend,
    input  logic [15:0] divisor,
    output logic        busy,
    output logic        conv_clr,
    output logic        valid,
    output logic [1:0]  digit,
    output logic        done,
    output logic        err
);

    localparam int DATA_W = 16;
    localparam int RES_W  = DATA_W + 3;
    localparam logic [3:0] LAST_DIGIT = 4'd15;
    localparam logic signed [RES_W-1:0] HALF = 19'sh08000;

    localparam logic [1:0] Q_POS  = 2'b10;
    localparam logic [1:0] Q_NEG  = 2'b01;
    localparam logic [1:0] Q_ZERO = 2'b00;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_ITER  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic signed [RES_W-1:0]  r_w;
    logic [DATA_W-1:0]        r_d;
    logic [3:0]               r_cnt;
    logic                     r_err;

    logic signed [RES_W-1:0]  w_t;
    logic [1:0]               w_q;
    logic signed [RES_W-1:0]  w_w_nxt;
    logic                     w_opnd_err;

    // Digit selection on the shifted residual: compare against +/- one half.
    function automatic logic [1:0] select_digit(input logic signed [RES_W-1:0] t);
        if (t >= HALF)
            return Q_POS;
        else if (t < -HALF)
            return Q_NEG;
        else
            return Q_ZERO;
    endfunction

    // Residual recurrence w' = 2w - q*d; |w| <= d keeps it inside 19 bits.
    function automatic logic signed [RES_W-1:0] residual_next(
        input logic signed [RES_W-1:0] t,
        input logic [1:0]              q,
        input logic [DATA_W-1:0]       d
    );
        logic signed [RES_W-1:0] dext;
        dext = $signed({3'b000, d});
        case (q)
            Q_POS:   return t - dext;
            Q_NEG:   return t + dext;
            default: return t;
        endcase
    endfunction

    assign w_t        = r_w <<< 1;
    assign w_q        = select_digit(w_t);
    assign w_w_nxt    = residual_next(w_t, w_q, r_d);
    // In CHECK the residual still holds the raw dividend in its low bits.
    assign w_opnd_err = ~r_d[DATA_W-1] | (r_w[DATA_W-1:0] >= r_d);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Next-state logic for IDLE -> CHECK -> ITER -> DONE -> IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_CHECK;
            S_CHECK: w_state_nxt = w_opnd_err ? S_DONE : S_ITER;
            S_ITER:  if (r_cnt == LAST_DIGIT) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Operand capture, residual iteration, digit counter and sticky error.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_w   <= '0;
            r_d   <= '0;
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_w   <= $signed({3'b000, dividend});
                        r_d   <= divisor;
                        r_err <= 1'b0;
                    end
                end
                S_CHECK: begin
                    r_cnt <= '0;
                    if (w_opnd_err)
                        r_err <= 1'b1;
                end
                S_ITER: begin
                    r_w   <= w_w_nxt;
                    r_cnt <= r_cnt + 4'd1;
                end
                default: ;
            endcase
        end
    end

    // Moore outputs decoded from the state; digits only qualified in ITER.
    always_comb begin
        busy     = (r_state != S_IDLE);
        conv_clr = (r_state == S_CHECK);
        valid    = (r_state == S_ITER);
        digit    = (r_state == S_ITER) ? w_q : Q_ZERO;
        done     = (r_state == S_DONE);
        err      = r_err;
    end

endmodule

// File: tb/tb_srt_digit_gen.sv
// Directed and random bench for srt_digit_gen with a transaction scoreboard.
module tb_srt_digit_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic        busy;
    logic        conv_clr;
    logic        valid;
    logic [1:0]  digit;
    logic        done;
    logic        err;

    int n_vec = 0;
    int n_mis = 0;

    typedef struct {
        logic err;
        int   cyc;
        int   ndig;
        int   qfloor;
    } exp_t;

    exp_t       sb[$];
    logic [1:0] digs[16];
    logic [1:0] ref_digs[16];
    logic [1:0] c2_head[6];
    int         last_q;

    srt_digit_gen dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .conv_clr (conv_clr),
        .valid    (valid),
        .digit    (digit),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic check_outputs_reset(input string tag);
        check({tag, ".busy"},     32'(busy),     32'd0);
        check({tag, ".conv_clr"}, 32'(conv_clr), 32'd0);
        check({tag, ".valid"},    32'(valid),    32'd0);
        check({tag, ".digit"},    32'(digit),    32'd0);
        check({tag, ".done"},     32'(done),     32'd0);
        check({tag, ".err"},      32'(err),      32'd0);
    endtask

    // One division: push expectation at start, collect digits, pop at done.
    task automatic run(input logic [15:0] x, input logic [15:0] d,
                       input bit pulse, input bit rel_rst, input string tag);
        exp_t e;
        exp_t got;
        int   cyc;
        int   ndig;
        int   q;
        bit   fin;
        bit   clr_bad;
        bit   dig_bad;
        e.err    = (d[15] == 1'b0) || (x >= d);
        e.cyc    = e.err ? 3 : 19;
        e.ndig   = e.err ? 0 : 16;
        e.qfloor = e.err ? 0 : int'((longint'(x) * 64'd65536) / longint'(d));
        sb.push_back(e);
        @(negedge clk);
        if (rel_rst) reset = 1'b0;
        dividend = x;
        divisor  = d;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        cyc     = 2;
        ndig    = 0;
        q       = 0;
        fin     = 1'b0;
        clr_bad = 1'b0;
        dig_bad = 1'b0;
        check({tag, ".busy"}, 32'(busy), 32'd1);
        for (int k = 0; k < 40 && !fin; k++) begin
            if (conv_clr !== (cyc == 2)) clr_bad = 1'b1;
            if (digit === 2'b11 || (valid !== 1'b1 && digit !== 2'b00)) dig_bad = 1'b1;
            if (valid === 1'b1) begin
                if (ndig < 16) begin
                    digs[ndig] = digit;
                    if (digit == 2'b10) q += (1 << (15 - ndig));
                    else if (digit == 2'b01) q -= (1 << (15 - ndig));
                end
                ndig++;
            end
            if (done === 1'b1) begin
                fin = 1'b1;
            end else begin
                start = pulse && (cyc == 8);
                @(posedge clk);
                #1;
                start = 1'b0;
                cyc++;
            end
        end
        got = sb.pop_front();
        check({tag, ".done_seen"}, 32'(fin),     32'd1);
        check({tag, ".done_cyc"},  32'(cyc),     32'(got.cyc));
        check({tag, ".err"},       32'(err),     32'(got.err));
        check({tag, ".ndig"},      32'(ndig),    32'(got.ndig));
        check({tag, ".conv_clr"},  32'(clr_bad), 32'd0);
        check({tag, ".digit_enc"}, 32'(dig_bad), 32'd0);
        if (!got.err) begin
            n_vec++;
            assert (q >= got.qfloor - 1 && q <= got.qfloor + 1) else begin
                n_mis++;
                $error("FAIL %s.q: observed %0h expected %0h +/-1", tag, q, got.qfloor);
            end
        end
        last_q = q;
        @(posedge clk);
        #1;
        check({tag, ".idle_busy"}, 32'(busy), 32'd0);
        check({tag, ".err_held"},  32'(err),  32'(got.err));
    endtask

    initial begin
        int nv;
        logic [15:0] rd;
        logic [15:0] rx;
        c2_head = '{2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b01};
        reset    = 1'b1;
        start    = 1'b0;
        dividend = 16'h0;
        divisor  = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        check_outputs_reset("reset");
        @(negedge clk);
        reset = 1'b0;

        // x = 0.25, d = 0.5: +1 then fifteen zeros.
        run(16'h4000, 16'h8000, 1'b0, 1'b0, "c1");
        check("c1.d0", 32'(digs[0]), 32'd2);
        for (int j = 1; j < 16; j++)
            check($sformatf("c1.d%0d", j), 32'(digs[j]), 32'd0);
        check("c1.Q", 32'(last_q), 32'h8000);

        // x = 0.125, d = 0.75: known leading digit pattern.
        run(16'h2000, 16'hC000, 1'b0, 1'b0, "c2");
        for (int j = 0; j < 6; j++)
            check($sformatf("c2.d%0d", j), 32'(digs[j]), 32'(c2_head[j]));
        for (int j = 0; j < 16; j++)
            ref_digs[j] = digs[j];

        // Operand errors.
        run(16'h1000, 16'h4000, 1'b0, 1'b0, "err_unnorm");
        run(16'h8000, 16'h8000, 1'b0, 1'b0, "err_ge");

        // Start pulsed mid-ITER must not disturb the run.
        run(16'h2000, 16'hC000, 1'b1, 1'b0, "pulse");
        for (int j = 0; j < 16; j++)
            check($sformatf("pulse.d%0d", j), 32'(digs[j]), 32'(ref_digs[j]));

        // Reset at the 8th valid digit.
        @(negedge clk);
        dividend = 16'h4000;
        divisor  = 16'hC000;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        nv    = 0;
        for (int k = 0; k < 40 && nv < 8; k++) begin
            @(posedge clk);
            #1;
            if (valid === 1'b1) nv++;
        end
        check("rst_mid.nv", 32'(nv), 32'd8);
        reset = 1'b1;
        #1;
        check_outputs_reset("rst_mid");
        @(posedge clk);
        #1;
        check_outputs_reset("rst_hold");
        run(16'h0000, 16'h8000, 1'b0, 1'b1, "after_rst");
        for (int j = 0; j < 16; j++)
            check($sformatf("after_rst.d%0d", j), 32'(digs[j]), 32'd0);

        // Random normalized operands with dividend < divisor.
        for (int i = 0; i < 2000; i++) begin
            rd = 16'($urandom_range(32'h8000, 32'hFFFF));
            rx = 16'($urandom_range(32'h0, 32'(rd) - 32'd1));
            run(rx, rd, 1'b0, 1'b0, $sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
